// File: rtl/systolic_result_drainer_pkg.sv
// Shared TPU definitions: drainer FSM encoding and counter sizing helper.
// Also used by the multiplier and MAC manager blocks.
package systolic_result_drainer_pkg;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } drainState_t;

    // Width of a counter that must hold every value from 0 up to and including depth.
    function automatic int cntWidth(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/systolic_result_drainer_drain_lane.sv
// One result row: counts accepted beats, stores them in column order and
// flags any beat that arrives when the row cannot take it.
module drain_lane
    import systolic_result_drainer_pkg::*;
#(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_clear,
    input  logic                   i_collect,
    input  logic                   i_valid,
    input  logic [ACC_WIDTH-1:0]   i_data,
    output logic [N*ACC_WIDTH-1:0] o_row,
    output logic                   o_fullNext,
    output logic                   o_overflow
);

    localparam int             CNT_W     = cntWidth(N);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [N*ACC_WIDTH-1:0] r_row;
    logic                 r_overflow;

    logic w_full;
    logic w_accept;
    logic w_last;

    assign w_full   = (r_cnt == CNT_MAX);
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_accept = i_valid && i_collect && !w_full;

    // Lets the top move to FULL on the same edge that stores the final beat.
    assign o_fullNext = w_full || (w_accept && w_last);
    assign o_row      = r_row;
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_row      <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (i_valid && !w_accept) begin
                r_overflow <= 1'b1;
            end

            for (int k = 0; k < N; k++) begin
                if (w_accept && (r_cnt == CNT_W'(k))) begin
                    r_row[k*ACC_WIDTH +: ACC_WIDTH] <= i_data;
                end
            end
        end
    end

endmodule

// File: rtl/systolic_result_drainer.sv
// Collects skewed per-row drain beats from an N x N systolic array and
// presents the complete row-major result matrix behind a valid/ready handshake.
module systolic_result_drainer
    import systolic_result_drainer_pkg::*;
#(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [N-1:0]             lane_valid,
    input  logic [N*ACC_WIDTH-1:0]   lane_data,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic [N*N*ACC_WIDTH-1:0] c_matrix,
    output logic                     overflow
);

    drainState_t r_state;
    drainState_t w_stateNext;

    logic [N-1:0] w_fullNext;
    logic [N-1:0] w_laneOverflow;
    logic         w_allFullNext;
    logic         w_collect;
    logic         w_handshake;

    assign w_collect     = (r_state == ST_COLLECT);
    assign w_handshake   = (r_state == ST_FULL) && c_ready;
    assign w_allFullNext = &w_fullNext;

    // Row i of the matrix is exactly the contiguous row register of lane i.
    for (genvar i = 0; i < N; i++) begin : g_lane
        drain_lane #(
            .N         (N),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_flush    (flush),
            .i_clear    (w_handshake),
            .i_collect  (w_collect),
            .i_valid    (lane_valid[i]),
            .i_data     (lane_data[ACC_WIDTH*i +: ACC_WIDTH]),
            .o_row      (c_matrix[ACC_WIDTH*N*i +: ACC_WIDTH*N]),
            .o_fullNext (w_fullNext[i]),
            .o_overflow (w_laneOverflow[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_COLLECT: if (w_allFullNext) w_stateNext = ST_FULL;
            ST_FULL:    if (c_ready)       w_stateNext = ST_COLLECT;
            default:                       w_stateNext = ST_COLLECT;
        endcase
        if (flush) begin
            w_stateNext = ST_COLLECT;
        end
    end

    assign c_valid  = (r_state == ST_FULL);
    assign overflow = |w_laneOverflow;

endmodule

// File: tb/tb_systolic_result_drainer.sv
// Self-checking bench for systolic_result_drainer (N=2, ACC_WIDTH=32):
// directed scenarios followed by random traffic against a behavioural model.
module tb_systolic_result_drainer;

    localparam int N = 2;
    localparam int W = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               flush = 1'b0;
    logic [N-1:0]       lane_valid = '0;
    logic [N*W-1:0]     lane_data = '0;
    logic               c_valid;
    logic               c_ready = 1'b0;
    logic [N*N*W-1:0]   c_matrix;
    logic               overflow;

    logic [W-1:0]       mRow [N][N];
    int                 mCnt [N];
    bit                 mFull = 1'b0;
    bit                 mOvf = 1'b0;
    bit                 mKnown = 1'b0;
    logic [N*N*W-1:0]   mExp = '0;

    int total = 0;
    int bad = 0;

    systolic_result_drainer #(
        .N         (N),
        .ACC_WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .c_matrix   (c_matrix),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                                 input logic rdy, input logic fl, input logic rst);
        lane_valid = v;
        lane_data  = {d1, d0};
        c_ready    = rdy;
        flush      = fl;
        reset      = rst;
    endtask

    // Reference behaviour: rows fill in arrival order, a full matrix is frozen until taken.
    task automatic modelStep();
        if (!reset) begin
            for (int r = 0; r < N; r++) mCnt[r] = 0;
            mFull  = 1'b0;
            mOvf   = 1'b0;
            mKnown = 1'b1;
            mExp   = '0;
        end else if (flush) begin
            for (int r = 0; r < N; r++) mCnt[r] = 0;
            mFull  = 1'b0;
            mOvf   = 1'b0;
            mKnown = 1'b0;
        end else if (mFull) begin
            if (lane_valid != '0) mOvf = 1'b1;
            if (c_ready) begin
                mFull  = 1'b0;
                mKnown = 1'b0;
                for (int r = 0; r < N; r++) mCnt[r] = 0;
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                if (lane_valid[r]) begin
                    if (mCnt[r] < N) begin
                        mRow[r][mCnt[r]] = lane_data[W*r +: W];
                        mCnt[r] = mCnt[r] + 1;
                        mKnown = 1'b0;
                    end else begin
                        mOvf = 1'b1;
                    end
                end
            end
            if (mCnt[0] == N && mCnt[1] == N) begin
                mFull  = 1'b1;
                mKnown = 1'b1;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        mExp[W*(r*N+c) +: W] = mRow[r][c];
            end
        end
    endtask

    task automatic checkOutput();
        total++;
        assert (c_valid === mFull) else begin
            bad++;
            $error("FAIL c_valid observed=%0b expected=%0b", c_valid, mFull);
        end
        total++;
        assert (overflow === mOvf) else begin
            bad++;
            $error("FAIL overflow observed=%0b expected=%0b", overflow, mOvf);
        end
        if (mKnown) begin
            total++;
            assert (c_matrix === mExp) else begin
                bad++;
                $error("FAIL c_matrix observed=%h expected=%h", c_matrix, mExp);
            end
        end
    endtask

    task automatic checkExact(input string tag, input logic [N*N*W-1:0] obs, input logic [N*N*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        // Reset with beats present: they must leave no trace.
        applyStimulus(2'b11, 32'd77, 32'd88, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkExact("reset_matrix", c_matrix, '0);
        checkExact("reset_valid", {127'd0, c_valid}, '0);

        // Skewed fill.
        applyStimulus(2'b01, 32'd10, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b11, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("skew_not_yet", {127'd0, c_valid}, '0);
        applyStimulus(2'b10, 32'd0, 32'd40, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("skew_valid", {127'd0, c_valid}, 128'd1);
        checkExact("skew_matrix", c_matrix, {32'd40, 32'd30, 32'd20, 32'd10});
        checkExact("skew_ovf", {127'd0, overflow}, '0);

        // Backpressure: matrix held while c_ready is low.
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick();
            checkExact("hold_matrix", c_matrix, {32'd40, 32'd30, 32'd20, 32'd10});
        end
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        checkExact("after_hs_valid", {127'd0, c_valid}, '0);
        applyStimulus(2'b11, 32'd1, 32'd3, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b11, 32'd2, 32'd4, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("second_matrix", c_matrix, {32'd4, 32'd3, 32'd2, 32'd1});

        // Beat during the handshake cycle is dropped.
        applyStimulus(2'b10, 32'd0, 32'd99, 1'b1, 1'b0, 1'b1);
        tick();
        checkExact("full_beat_ovf", {127'd0, overflow}, 128'd1);
        applyStimulus(2'b11, 32'd51, 32'd53, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b11, 32'd52, 32'd54, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("post_drop_matrix", c_matrix, {32'd54, 32'd53, 32'd52, 32'd51});
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        tick();
        checkExact("flush_clears_ovf", {127'd0, overflow}, '0);

        // Overrun on lane 0 before lane 1 starts.
        applyStimulus(2'b01, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b01, 32'd6, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b01, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("overrun_ovf", {127'd0, overflow}, 128'd1);
        applyStimulus(2'b10, 32'd0, 32'd8, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b10, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("overrun_matrix", c_matrix, {32'd9, 32'd8, 32'd6, 32'd5});
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();

        // Flush mid-collection with a simultaneous beat.
        applyStimulus(2'b01, 32'd11, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b10, 32'd0, 32'd22, 1'b0, 1'b1, 1'b1);
        tick();
        checkExact("flush_ovf", {127'd0, overflow}, '0);
        applyStimulus(2'b11, 32'd61, 32'd63, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("flush_restart", {127'd0, c_valid}, '0);
        applyStimulus(2'b11, 32'd62, 32'd64, 1'b0, 1'b0, 1'b1);
        tick();
        checkExact("flush_fresh_matrix", c_matrix, {32'd64, 32'd63, 32'd62, 32'd61});

        // Reset while full and c_ready high.
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkExact("rst_full_valid", {127'd0, c_valid}, '0);
        checkExact("rst_full_matrix", c_matrix, '0);
        applyStimulus(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(2'($urandom), $urandom, $urandom,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 79) != 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
